// File: rtl/ws2812_frame_ctrl.sv
// WS2812 frame sequencer: tracks frame gaps, bit/LED counts and truncation after
// MAX_LEDS, and gates the reshaper passthrough; a stuck-high line forces a sticky fault.
module ws2812_frame_ctrl #(
  parameter int unsigned RESET_CYCLES = 3000,
  parameter int unsigned STUCK_CYCLES = 1023,
  parameter int unsigned TAIL_CYCLES  = 16,
  parameter int unsigned BITS_PER_LED = 24,
  parameter int unsigned MAX_LEDS     = 64,
  parameter int unsigned LED_W        = 8
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_signal_synced,
  input  logic             i_enable,
  input  logic             i_fault_clr,
  output logic             o_passthru_en,
  output logic             o_frame_start,
  output logic             o_frame_done,
  output logic [LED_W-1:0] o_led_count,
  output logic             o_partial,
  output logic             o_truncated,
  output logic             o_fault
);

  localparam int unsigned LOW_W  = $clog2(RESET_CYCLES + 1);
  localparam int unsigned HIGH_W = $clog2(STUCK_CYCLES + 1);
  localparam int unsigned BIT_W  = $clog2(BITS_PER_LED + 1);

  typedef enum logic [2:0] {
    S_SYNC,
    S_IDLE,
    S_FRAME,
    S_TAIL,
    S_BLOCK,
    S_FAULT
  } state_t;

  state_t             state;
  logic               prev;
  logic               pass_q;
  logic               last;
  logic               trunc;
  logic [LOW_W-1:0]   low_cnt;
  logic [HIGH_W-1:0]  high_cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic [BIT_W-1:0]   bit_nxt;
  logic [LED_W-1:0]   led_cnt;
  logic [LED_W-1:0]   led_nxt;
  logic               rise;
  logic               gap_done;
  logic               tail_done;
  logic               stuck;

  assign rise      = i_signal_synced & ~prev;
  assign gap_done  = (low_cnt == LOW_W'(RESET_CYCLES));
  assign tail_done = (low_cnt == LOW_W'(TAIL_CYCLES));
  assign stuck     = (high_cnt == HIGH_W'(STUCK_CYCLES));

  always_comb begin
    bit_nxt = bit_cnt + 1'b1;
    led_nxt = led_cnt;
    if (bit_nxt == BIT_W'(BITS_PER_LED)) begin
      bit_nxt = '0;
      if (led_cnt != '1) led_nxt = led_cnt + 1'b1;
    end
  end

  // A new high in S_TAIL is a blocked bit: suppress it before the state register catches up.
  assign o_passthru_en = pass_q & ~((state == S_TAIL) & i_signal_synced);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state         <= S_SYNC;
      prev          <= 1'b1;
      pass_q        <= 1'b0;
      last          <= 1'b0;
      trunc         <= 1'b0;
      low_cnt       <= '0;
      high_cnt      <= '0;
      bit_cnt       <= '0;
      led_cnt       <= '0;
      o_frame_start <= 1'b0;
      o_frame_done  <= 1'b0;
      o_led_count   <= '0;
      o_partial     <= 1'b0;
      o_truncated   <= 1'b0;
      o_fault       <= 1'b0;
    end else begin
      prev          <= i_signal_synced;
      o_frame_start <= 1'b0;
      o_frame_done  <= 1'b0;

      if (i_signal_synced) begin
        low_cnt <= '0;
        if (!stuck) high_cnt <= high_cnt + 1'b1;
      end else begin
        high_cnt <= '0;
        if (!gap_done) low_cnt <= low_cnt + 1'b1;
      end

      if (stuck) begin
        state   <= S_FAULT;
        pass_q  <= 1'b0;
        o_fault <= 1'b1;
      end else if (!i_enable && state != S_FAULT) begin
        // Quiet-line detection restarts from zero once re-enabled.
        state   <= S_SYNC;
        pass_q  <= 1'b0;
        low_cnt <= '0;
        bit_cnt <= '0;
        led_cnt <= '0;
        last    <= 1'b0;
        trunc   <= 1'b0;
      end else begin
        case (state)
          S_SYNC: begin
            if (gap_done) begin
              state  <= S_IDLE;
              pass_q <= 1'b1;
            end
          end
          S_IDLE: begin
            if (rise) begin
              state         <= S_FRAME;
              o_frame_start <= 1'b1;
              bit_cnt       <= BIT_W'(1);
              led_cnt       <= '0;
              last          <= 1'b0;
              trunc         <= 1'b0;
            end
          end
          S_FRAME: begin
            if (last && !i_signal_synced) begin
              state <= S_TAIL;
            end else if (gap_done) begin
              state        <= S_IDLE;
              o_frame_done <= 1'b1;
              o_led_count  <= led_cnt;
              o_partial    <= (bit_cnt != '0);
              o_truncated  <= 1'b0;
            end else if (rise) begin
              bit_cnt <= bit_nxt;
              led_cnt <= led_nxt;
              if (led_nxt == LED_W'(MAX_LEDS)) last <= 1'b1;
            end
          end
          S_TAIL: begin
            if (rise) begin
              state   <= S_BLOCK;
              pass_q  <= 1'b0;
              trunc   <= 1'b1;
              bit_cnt <= bit_nxt;
              led_cnt <= led_nxt;
            end else if (tail_done) begin
              state  <= S_BLOCK;
              pass_q <= 1'b0;
            end
          end
          S_BLOCK: begin
            if (gap_done) begin
              state        <= S_IDLE;
              pass_q       <= 1'b1;
              o_frame_done <= 1'b1;
              o_led_count  <= led_cnt;
              o_partial    <= (bit_cnt != '0);
              o_truncated  <= trunc;
            end else if (rise) begin
              trunc   <= 1'b1;
              bit_cnt <= bit_nxt;
              led_cnt <= led_nxt;
            end
          end
          S_FAULT: begin
            if (i_fault_clr) begin
              state   <= S_SYNC;
              o_fault <= 1'b0;
              low_cnt <= '0;
            end
          end
          default: begin
            state  <= S_SYNC;
            pass_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// Self-checking bench for ws2812_frame_ctrl with MAX_LEDS=2: frame table, random frames
// against a frame-level model, and hand sequences for tail timing, fault, enable and reset.
module tb_ws2812_frame_ctrl;

  localparam int RST  = 3000;
  localparam int STK  = 1023;
  localparam int TAIL = 16;
  localparam int BPL  = 24;
  localparam int MAXL = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sig = 1'b0;
  logic       en = 1'b1;
  logic       clr = 1'b0;
  logic       pass;
  logic       fstart;
  logic       fdone;
  logic [7:0] led_count;
  logic       partial;
  logic       truncated;
  logic       fault;

  int n_cmp = 0;
  int n_bad = 0;
  int starts = 0;
  int dones = 0;
  int leaks = 0;
  int misses = 0;
  int bit_idx = 0;
  logic track = 1'b0;
  logic allow = 1'b0;
  int last_leds = 0;

  typedef struct {
    int nbits;
    int hi;
    int lo;
    int leds;
    int part;
    int trunc;
  } vec_t;

  vec_t tbl[8];

  ws2812_frame_ctrl #(
    .RESET_CYCLES(RST),
    .STUCK_CYCLES(STK),
    .TAIL_CYCLES (TAIL),
    .BITS_PER_LED(BPL),
    .MAX_LEDS    (MAXL),
    .LED_W       (8)
  ) dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_signal_synced(sig),
    .i_enable       (en),
    .i_fault_clr    (clr),
    .o_passthru_en  (pass),
    .o_frame_start  (fstart),
    .o_frame_done   (fdone),
    .o_led_count    (led_count),
    .o_partial      (partial),
    .o_truncated    (truncated),
    .o_fault        (fault)
  );

  always #5 clk = ~clk;

  // Frame-level observer: pulse counts and passthrough of allowed/blocked bit highs.
  always @(posedge clk) begin
    #1;
    if (fstart) starts++;
    if (fdone) dones++;
    if (track && sig) begin
      if (allow && !pass) misses++;
      if (!allow && pass) leaks++;
    end
  end

  initial begin
    #1_200_000;
    $display("FAIL watchdog: simulation time limit reached (got timeout, required finish)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  function automatic int model_leds(input int nbits);
    int l;
    l = nbits / BPL;
    return (l > 255) ? 255 : l;
  endfunction

  task automatic send_bit(input int hi, input int lo);
    allow = (bit_idx < MAXL * BPL);
    track = 1'b1;
    sig = 1'b1;
    repeat (hi) @(negedge clk);
    sig = 1'b0;
    repeat (lo) @(negedge clk);
    bit_idx++;
  endtask

  task automatic gap(input int cycles);
    sig = 1'b0;
    track = 1'b0;
    bit_idx = 0;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic wait_pass(input int bound, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!pass && n < bound);
    @(negedge clk);
  endtask

  task automatic run_frame(input string tag, input int nbits, input int hi, input int lo,
                           input int leds, input int part, input int trunc);
    int s0, d0, m0, l0;
    s0 = starts; d0 = dones; m0 = misses; l0 = leaks;
    bit_idx = 0;
    for (int b = 0; b < nbits; b++) send_bit(hi, lo);
    gap(RST + 20);
    check({tag, "_start"}, starts - s0, 1);
    check({tag, "_done"}, dones - d0, 1);
    check({tag, "_leds"}, int'(led_count), leds);
    check({tag, "_partial"}, int'(partial), part);
    check({tag, "_trunc"}, int'(truncated), trunc);
    check({tag, "_miss"}, misses - m0, 0);
    check({tag, "_leak"}, leaks - l0, 0);
    check({tag, "_pass_idle"}, int'(pass), 1);
    last_leds = leds;
  endtask

  initial begin
    int n, s0, d0, m0, l0, nb, hi, lo, p, t;

    tbl[0] = '{nbits: 24,   hi: 4, lo: 4, leds: 1,   part: 0, trunc: 0};
    tbl[1] = '{nbits: 48,   hi: 3, lo: 5, leds: 2,   part: 0, trunc: 0};
    tbl[2] = '{nbits: 72,   hi: 4, lo: 4, leds: 3,   part: 0, trunc: 1};
    tbl[3] = '{nbits: 30,   hi: 5, lo: 3, leds: 1,   part: 1, trunc: 0};
    tbl[4] = '{nbits: 1,    hi: 2, lo: 2, leds: 0,   part: 1, trunc: 0};
    tbl[5] = '{nbits: 50,   hi: 1, lo: 1, leds: 2,   part: 1, trunc: 1};
    tbl[6] = '{nbits: 49,   hi: 2, lo: 3, leds: 2,   part: 1, trunc: 1};
    tbl[7] = '{nbits: 6144, hi: 1, lo: 1, leds: 255, part: 0, trunc: 1};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_pass", int'(pass), 0);
    check("rst_start", int'(fstart), 0);
    check("rst_done", int'(fdone), 0);
    check("rst_leds", int'(led_count), 0);
    check("rst_partial", int'(partial), 0);
    check("rst_trunc", int'(truncated), 0);
    check("rst_fault", int'(fault), 0);
    rst_n = 1'b1;
    wait_pass(RST + 100, n);
    check("sync_latency", n, RST + 1);

    foreach (tbl[i])
      run_frame($sformatf("tbl%0d", i), tbl[i].nbits, tbl[i].hi, tbl[i].lo,
                tbl[i].leds, tbl[i].part, tbl[i].trunc);

    // Tail timing: passthrough holds TAIL low cycles after bit 48 falls
    s0 = starts; d0 = dones; m0 = misses; l0 = leaks;
    bit_idx = 0;
    for (int b = 0; b < 47; b++) send_bit(3, 3);
    allow = 1'b1;
    sig = 1'b1;
    repeat (3) @(negedge clk);
    sig = 1'b0;
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      if (!pass) break;
      n++;
    end
    @(negedge clk);
    check("tail_hold", n, TAIL);
    bit_idx = 48;
    for (int b = 0; b < 24; b++) send_bit(3, 3);
    gap(RST + 20);
    check("tail_start", starts - s0, 1);
    check("tail_done", dones - d0, 1);
    check("tail_leds", int'(led_count), 3);
    check("tail_trunc", int'(truncated), 1);
    check("tail_miss", misses - m0, 0);
    check("tail_leak", leaks - l0, 0);

    // Random frames against the frame-level model
    for (int r = 0; r < 5; r++) begin
      nb = $urandom_range(1, 100);
      hi = $urandom_range(1, 5);
      lo = $urandom_range(1, 5);
      p  = (nb % BPL) != 0 ? 1 : 0;
      t  = (nb > MAXL * BPL) ? 1 : 0;
      run_frame($sformatf("rnd%0d", r), nb, hi, lo, model_leds(nb), p, t);
    end

    // Fault clear outside S_FAULT is ignored
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (2) @(negedge clk);
    check("clr_ignored_pass", int'(pass), 1);
    check("clr_ignored_fault", int'(fault), 0);

    // Enable dropped mid-frame
    d0 = dones;
    bit_idx = 0;
    for (int b = 0; b < 10; b++) send_bit(3, 3);
    track = 1'b0;
    en = 1'b0;
    @(posedge clk);
    #1;
    check("en_drop_pass", int'(pass), 0);
    @(negedge clk);
    repeat (9) @(negedge clk);
    en = 1'b1;
    check("en_still_blocked", int'(pass), 0);
    wait_pass(RST + 100, n);
    check("en_resync", n, RST + 1);
    check("en_no_done", dones - d0, 0);
    check("en_status_kept", int'(led_count), last_leds);

    // Stuck-high line mid-frame
    d0 = dones;
    bit_idx = 0;
    for (int b = 0; b < 10; b++) send_bit(3, 3);
    track = 1'b0;
    sig = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!fault && n < STK + 100);
    check("stuck_latency", n, STK + 1);
    check("stuck_pass", int'(pass), 0);
    @(negedge clk);
    sig = 1'b0;
    repeat (20) @(negedge clk);
    check("fault_sticky", int'(fault), 1);
    check("fault_pass", int'(pass), 0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("fault_cleared", int'(fault), 0);
    wait_pass(RST + 100, n);
    check("fault_resync", n, RST + 1);
    check("fault_no_done", dones - d0, 0);

    // Reset pulse mid-frame
    bit_idx = 0;
    for (int b = 0; b < 5; b++) send_bit(3, 3);
    track = 1'b0;
    sig = 1'b1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_pass", int'(pass), 0);
    check("midrst_start", int'(fstart), 0);
    check("midrst_done", int'(fdone), 0);
    check("midrst_leds", int'(led_count), 0);
    check("midrst_partial", int'(partial), 0);
    check("midrst_trunc", int'(truncated), 0);
    check("midrst_fault", int'(fault), 0);
    @(negedge clk);
    rst_n = 1'b1;
    sig = 1'b0;
    wait_pass(RST + 100, n);
    check("midrst_resync", n, RST + 1);
    run_frame("post_rst", 24, 4, 4, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ws2812_frame_ctrl.md
Name: ws2812_frame_ctrl

Overview:
- Sequencer that drives the passthrough enable of the WS2812 reshaper from the synced input stream.
- Tracks frame boundaries (latch/reset gaps), bit and LED counts, and downstream truncation after MAX_LEDS.
- Detects a stuck-high line and gates output safely.
- Sits between the input synchroniser and the reshaper. Status outputs go to the register/debug block.

Parameters:
- RESET_CYCLES, 3000, consecutive low cycles that mark a frame gap/latch (≥50 µs at 60 MHz).
- STUCK_CYCLES, 1023, consecutive high cycles that flag a stuck line.
- TAIL_CYCLES, 16, low cycles held after the final allowed bit before truncation (covers reshaper pulse extension).
- BITS_PER_LED, 24, bits per LED word.
- MAX_LEDS, 64, LEDs forwarded per frame; later bits are blocked.
- LED_W, 8, width of LED count; must hold MAX_LEDS.

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  synchronous active-low reset.
- i_signal_synced  in  1  synchronised WS2812 input.
- i_enable  in  1  controller enable; low forces S_SYNC.
- i_fault_clr  in  1  one-cycle pulse; clears sticky fault.
- o_passthru_en  out  1  to reshaper i_passthru_en.
- o_frame_start  out  1  one-cycle pulse on first rising edge of a frame.
- o_frame_done  out  1  one-cycle pulse when a frame's reset gap completes.
- o_led_count  out  LED_W  complete LEDs of last finished frame (forwarded plus blocked, saturating at 2^LED_W-1).
- o_partial  out  1  last finished frame ended mid-LED (bit count ≠ 0).
- o_truncated  out  1  last finished frame exceeded MAX_LEDS.
- o_fault  out  1  sticky stuck-high fault.

Behaviour:
- Reset (i_reset_n low at posedge):
  - State S_SYNC; all counters 0.
  - All outputs 0; o_passthru_en 0.
- Line monitors:
  - low_cnt: +1 while synced=0, saturating at RESET_CYCLES, cleared when synced=1.
  - high_cnt: mirror image, saturating at STUCK_CYCLES.
  - Rising edge = synced=1 and registered previous sample=0. The previous-sample register resets to 1, so no edge is detected right after reset.
- States (o_passthru_en is a registered Moore output, 1 only in S_IDLE, S_FRAME, S_TAIL):
  - S_SYNC: wait for line quiet.
    - low_cnt==RESET_CYCLES → S_IDLE.
  - S_IDLE: gap seen, waiting for data.
    - Rising edge → S_FRAME; pulse o_frame_start; bit_cnt=1, led_cnt=0.
  - S_FRAME: each rising edge increments bit_cnt.
    - bit_cnt reaching BITS_PER_LED wraps to 0 and increments led_cnt.
    - When led_cnt becomes MAX_LEDS, set last flag.
    - Last flag set and synced=0 → S_TAIL.
    - low_cnt==RESET_CYCLES → S_IDLE: pulse o_frame_done; latch o_led_count, o_partial=(bit_cnt≠0), o_truncated=0.
  - S_TAIL: keep passthru enabled so the reshaper can finish the final bit.
    - low_cnt==TAIL_CYCLES → S_BLOCK.
    - Rising edge earlier → S_BLOCK immediately, and o_passthru_en is combinationally forced 0 while synced=1 in S_TAIL (no leaked pulse).
  - S_BLOCK: o_passthru_en=0; keep counting bits/LEDs.
    - low_cnt==RESET_CYCLES → S_IDLE: pulse o_frame_done; latch counts, o_truncated=1 if any rising edge was seen after entering S_TAIL, else 0.
  - S_FAULT: o_passthru_en=0, o_fault=1.
    - i_fault_clr → S_SYNC and o_fault=0 on the next cycle. The line must then be quiet again before passthrough resumes.
- Priority per cycle, highest first:
  1. Reset.
  2. high_cnt==STUCK_CYCLES → S_FAULT, from any state including S_SYNC.
  3. i_enable=0 → S_SYNC; counters cleared; status latches kept.
  4. Normal transitions.
- Simultaneous events:
  - Fault and frame completion in the same cycle: fault wins, no o_frame_done.
  - i_fault_clr while not in S_FAULT: ignored.
- Wrap and saturation:
  - led_cnt saturates at 2^LED_W-1.
  - bit_cnt wraps modulo BITS_PER_LED.
- Mid-frame events:
  - i_enable deasserted mid-frame: passthru drops the next cycle; no o_frame_done.
- Latency:
  - S_IDLE entered the cycle after low_cnt hits RESET_CYCLES.
  - o_frame_start asserted the cycle after the sample in which the rising edge is detected.

Test Plan:
- Reset released with line low for 3000 cycles, then a 24-bit frame and a 3000-cycle gap → o_passthru_en rises after the gap; one o_frame_start; one o_frame_done; o_led_count=1, o_partial=0, o_truncated=0.
- MAX_LEDS=2, send 3 LEDs (72 bits) → passthru falls 16 low cycles after bit 48's fall (before bit 49's rising edge); on done o_led_count=3, o_truncated=1.
- MAX_LEDS=2, send exactly 48 bits then the gap → traverses S_TAIL/S_BLOCK; o_truncated=0; o_led_count=2.
- Send 30 bits then the gap → o_led_count=1, o_partial=1.
- Hold line high 1023 cycles mid-frame → o_fault=1, passthru 0, no o_frame_done; pulse i_fault_clr with line low → o_fault=0; passthru returns only after 3000 low cycles.
- Drop i_enable mid-frame, restore it after 10 cycles → passthru 0 the next cycle; S_SYNC re-entered; no o_frame_done for the aborted frame.
- Assert i_reset_n low for 1 cycle mid-frame → all outputs 0 on the next cycle.
